// File: rtl/multdiv_unit_if.sv
// Operation handshake between the execute stage and the multiply/divide unit.
// Carries the start controls, both operands and the completion result/flags.
// master = processor side, slave = multdiv_unit.
interface multdiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output ctrl_MULT,
    output ctrl_DIV,
    output data_operandA,
    output data_operandB,
    input  data_result,
    input  data_exception,
    input  data_resultRDY
  );

  modport slave (
    input  ctrl_MULT,
    input  ctrl_DIV,
    input  data_operandA,
    input  data_operandB,
    output data_result,
    output data_exception,
    output data_resultRDY
  );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit, one op in flight.
// Latency: start sampled at edge N, data_resultRDY pulses for the cycle after edge N+WIDTH+1.
// No backpressure: a start in any state abandons the current op and restarts the latency.
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic           clock,
  input  logic           reset,
  multdiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_n;

  // Shared datapath registers:
  //   MUL: hi = Booth accumulator (one guard bit), lo = multiplier, qm1 = Booth history bit,
  //        m = multiplicand.
  //   DIV: hi = partial remainder, lo = dividend magnitude shifting out / quotient shifting in,
  //        m = divisor magnitude.
  logic [WIDTH:0]   hi;
  logic [WIDTH-1:0] lo;
  logic             qm1;
  logic [WIDTH-1:0] m;
  logic [CNT_W-1:0] cnt;

  // Divide side-information captured at start.
  logic             div_neg;
  logic             div_zero;
  logic             div_ovf;

  logic [WIDTH-1:0] res_q;
  logic             exc_q;

  logic start;
  logic last;
  assign start = bus.ctrl_MULT | bus.ctrl_DIV;
  // cnt reaches WIDTH after the last iteration; that cycle finalises the result.
  assign last  = (cnt == CNT_W'(WIDTH));

  // Operand magnitudes for divide.
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  assign a_mag = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + 1'b1) : bus.data_operandA;
  assign b_mag = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + 1'b1) : bus.data_operandB;

  // Booth step: add/subtract the multiplicand per {lo[0], qm1}, then arithmetic shift right.
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   booth_hi;
  logic [WIDTH-1:0] booth_lo;
  always_comb begin
    m_ext     = {m[WIDTH-1], m};
    booth_sum = hi;
    case ({lo[0], qm1})
      2'b01:   booth_sum = hi + m_ext;
      2'b10:   booth_sum = hi - m_ext;
      default: booth_sum = hi;
    endcase
    booth_hi = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    booth_lo = {booth_sum[0], lo[WIDTH-1:1]};
  end

  // Restoring divide step: shift in the next dividend bit and try subtracting the divisor.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   div_hi;
  logic [WIDTH-1:0] div_lo;
  always_comb begin
    rem_sh = {hi[WIDTH-1:0], lo[WIDTH-1]};
    trial  = {1'b0, rem_sh} - {2'b00, m};
    if (!trial[WIDTH+1]) begin
      div_hi = trial[WIDTH:0];
      div_lo = {lo[WIDTH-2:0], 1'b1};
    end else begin
      div_hi = rem_sh;
      div_lo = {lo[WIDTH-2:0], 1'b0};
    end
  end

  // Final result/exception selection once all iterations are done.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     prod_top;
  logic [WIDTH-1:0]   fin_res;
  logic               fin_exc;
  always_comb begin
    prod     = {hi[WIDTH-1:0], lo};
    prod_top = prod[2*WIDTH-1:WIDTH-1];
    fin_res  = '0;
    fin_exc  = 1'b0;
    if (state == S_MUL) begin
      fin_res = lo;
      // Product fits in WIDTH signed bits only if the top WIDTH+1 bits agree.
      fin_exc = !((&prod_top) || !(|prod_top));
    end else begin
      if (div_zero) begin
        fin_res = '0;
        fin_exc = 1'b1;
      end else begin
        // -2^(W-1) / -1 yields magnitude 2^(W-1) with positive sign, which wraps to itself.
        fin_res = div_neg ? (~lo + 1'b1) : lo;
        fin_exc = div_ovf;
      end
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state logic; a start wins from every state, MUL wins if both controls are set.
  always_comb begin
    state_n = state;
    if (start) begin
      state_n = bus.ctrl_MULT ? S_MUL : S_DIV;
    end else begin
      case (state)
        S_IDLE:  state_n = S_IDLE;
        S_MUL:   state_n = last ? S_DONE : S_MUL;
        S_DIV:   state_n = last ? S_DONE : S_DIV;
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Datapath: load on start, iterate while busy, capture the final result into the outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      qm1      <= 1'b0;
      m        <= '0;
      cnt      <= '0;
      div_neg  <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      res_q    <= '0;
      exc_q    <= 1'b0;
    end else if (start) begin
      cnt      <= '0;
      hi       <= '0;
      qm1      <= 1'b0;
      div_neg  <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      div_zero <= (bus.data_operandB == '0);
      div_ovf  <= (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                  (bus.data_operandB == {WIDTH{1'b1}});
      if (bus.ctrl_MULT) begin
        m  <= bus.data_operandA;
        lo <= bus.data_operandB;
      end else begin
        m  <= b_mag;
        lo <= a_mag;
      end
    end else if ((state == S_MUL) || (state == S_DIV)) begin
      if (!last) begin
        cnt <= cnt + CNT_W'(1);
        if (state == S_MUL) begin
          hi  <= booth_hi;
          lo  <= booth_lo;
          qm1 <= lo[0];
        end else begin
          hi <= div_hi;
          lo <= div_lo;
        end
      end else begin
        res_q <= fin_res;
        exc_q <= fin_exc;
      end
    end
  end

  assign bus.data_result    = res_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = (state == S_DONE);

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
Iterative signed 32-bit multiply/divide unit used by the processor's execute stage for mul and div instructions. The processor pulses a start control and stalls until the unit pulses a ready. The processor then writes the result back through the regfile write port, which is what the cycle trace logs. It is a multicycle functional unit with fixed latency and no pipelining: one operation is in flight at a time.

Parameters:
WIDTH, 32, operand/result width; the iteration count equals WIDTH.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high; clears all state immediately.
ctrl_MULT  input  1  start a signed multiply; sampled on the rising edge.
ctrl_DIV  input  1  start a signed divide; sampled on the rising edge.
data_operandA  input  WIDTH  multiplicand or dividend; sampled only on the start edge.
data_operandB  input  WIDTH  multiplier or divisor; sampled only on the start edge.
data_result  output  WIDTH  low WIDTH bits of the product, or the quotient.
data_exception  output  1  overflow or divide-by-zero flag for the completed operation.
data_resultRDY  output  1  one-cycle pulse marking the completed operation.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - data_result=0, data_exception=0, data_resultRDY=0.
  - State goes to IDLE and the counter goes to 0.
  - An in-flight operation is discarded and its RDY never occurs.
- States: IDLE, MUL, DIV, DONE.
- Start edge: a rising edge with ctrl_MULT=1 or ctrl_DIV=1.
  - Latches both operands and the op type; the counter goes to 0.
  - Next state is MUL or DIV.
  - If both controls are 1, the op is MUL.
- MUL: radix-2 signed shift-add (Booth recoding permitted) over a 2*WIDTH accumulator; one iteration per cycle; WIDTH iterations.
- DIV: operands are converted to magnitudes; restoring or non-restoring division; one quotient bit per cycle; WIDTH iterations.
  - The quotient sign is the XOR of the operand signs.
  - Truncation is toward zero; the remainder is discarded.
- After the last iteration the state is DONE for exactly one cycle:
  - data_resultRDY=1.
  - data_result and data_exception show the final values.
  - The next state is IDLE, unless a new start occurs on that same edge.
- Latency: start sampled at edge N, so data_resultRDY is high between edges N+WIDTH+1 and N+WIDTH+2.
  - With WIDTH=32 this is 33 edges after the start edge.
- data_result and data_exception hold their last completed values until the next DONE or a reset; they are not cleared at a start.
- Exceptions:
  - MUL: exception=1 when the full 2*WIDTH signed product does not fit in WIDTH signed bits, i.e. the upper WIDTH+1 bits are not all equal. Result = low WIDTH bits.
  - DIV by zero: exception=1, result=0. The unit still takes the full latency (no early exit).
  - DIV of -2^(WIDTH-1) by -1: exception=1, result=0x80000000.
- Start while busy (MUL/DIV/DONE): the current operation is abandoned and no RDY is issued for it. The new operands are latched and the latency restarts from this edge.
- Operand inputs may change freely after the start edge without affecting the result.
- data_resultRDY is never high for two consecutive cycles.

Test Plan:
- Reset; start ctrl_MULT at edge 0 with A=6, B=7; hold the controls low afterwards -> RDY only during cycle 33, result=42, exception=0; result stays 42 through cycle 40.
- MULT A=-5, B=3 -> result=-15 (0xFFFFFFF1), exc=0. MULT A=65536, B=65536 -> result=0, exc=1. MULT A=-65536, B=32768 -> result=-2147483648, exc=0.
- DIV A=7, B=2 -> 3. DIV A=-7, B=2 -> -3. DIV A=7, B=-2 -> -3. All with exc=0 and RDY at +33.
- DIV A=5, B=0 -> result=0, exc=1 at +33. DIV A=0x80000000, B=-1 -> result=0x80000000, exc=1.
- Start MULT 3*4; at edge 10 start DIV 100/7 -> no RDY near edge 33; a single RDY at edge 43 with result=14.
- Start MULT 9*9; assert reset asynchronously between edges 15 and 16 -> outputs 0 immediately and no RDY within 50 cycles. Then start MULT 2*3 -> result=6 at +33.
- Assert ctrl_MULT and ctrl_DIV together with A=8, B=2 -> result=16 (multiply).
